wfi_ctrl: RTL and testbench

//  Sequences WFI in the M stage: holds the pipeline while memory traffic drains, then sleeps until
//  an interrupt is pending or the TW/U-mode timeout expires. On wakeup the WFI retires as a nop;
//  on timeout it raises an illegal-instruction cause. Sits beside the privileged decoder in privileged

---
 rtl/wfi_ctrl_pkg.sv | 23 ++
 rtl/wfi_ctrl.sv | 106 ++++++++++
 tb/tb_wfi_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wfi_ctrl_pkg.sv
// Shared WFI sequencing types and privilege encodings.
// The trace monitor decodes wfistate_t, so keep the enum order stable.
package wfi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    SLEEP   = 3'd2,
    WAKE    = 3'd3,
    TIMEOUT = 3'd4
  } wfistate_t;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // TW forces a timeout outside M mode; with S-mode present, U-mode WFI always times out.
  function automatic logic timeoutEnable(input logic uSup, input logic sSup,
                                         input logic tw, input logic [1:0] priv);
    return uSup & ((tw & (priv != PRIV_M)) | (sSup & (priv == PRIV_U)));
  endfunction

endpackage

// File: rtl/wfi_ctrl.sv
// WFI sequencer in the M stage: drains memory traffic, sleeps until an interrupt
// is pending or the TW/U-mode timeout expires, then retires as a nop or traps.
module wfi_ctrl
  import wfi_ctrl_pkg::*;
#(
  parameter int WFI_TIMEOUT_BIT = 16,
  parameter bit U_SUPPORTED     = 1'b1,
  parameter bit S_SUPPORTED     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wfiM,
  input  logic       StallM,
  input  logic       FlushM,
  input  logic       PendingIntsM,
  input  logic       LSUBusyM,
  input  logic [1:0] PrivilegeModeW,
  input  logic       STATUS_TW,
  output logic       WFIStallM,
  output logic       SleepM,
  output logic       WFITimeoutM,
  output logic       WFIDoneM
);

  wfistate_t state, nextState;
  logic      waiting;
  logic      cntMsb;
  logic      toEn;

  assign waiting = (state == DRAIN) | (state == SLEEP);
  assign toEn    = timeoutEnable(U_SUPPORTED, S_SUPPORTED, STATUS_TW, PrivilegeModeW);

  // Saturating wait counter; without U mode there is no timeout and no counter.
  generate
    if (U_SUPPORTED) begin : gCnt
      localparam logic [WFI_TIMEOUT_BIT:0] CNT_ONE = 1;
      logic [WFI_TIMEOUT_BIT:0] cnt;

      always_ff @(posedge clk) begin
        if (reset || state == IDLE)
          cnt <= '0;
        else if (waiting && !cnt[WFI_TIMEOUT_BIT])
          cnt <= cnt + CNT_ONE;
      end

      assign cntMsb = cnt[WFI_TIMEOUT_BIT];
    end else begin : gNoCnt
      assign cntMsb = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    WFIStallM   = 1'b0;
    SleepM      = 1'b0;
    WFITimeoutM = 1'b0;
    WFIDoneM    = 1'b0;

    case (state)
      IDLE: begin
        WFIStallM = wfiM & ~PendingIntsM & ~FlushM;
        WFIDoneM  = wfiM & PendingIntsM & ~FlushM & ~StallM;
        if (wfiM && !PendingIntsM && !FlushM) nextState = DRAIN;
      end
      DRAIN: begin
        WFIStallM = 1'b1;
        if      (FlushM)          nextState = IDLE;
        else if (PendingIntsM)    nextState = WAKE;
        else if (toEn && cntMsb)  nextState = TIMEOUT;
        else if (!LSUBusyM)       nextState = SLEEP;
      end
      SLEEP: begin
        WFIStallM = 1'b1;
        SleepM    = 1'b1;
        if      (FlushM)          nextState = IDLE;
        else if (PendingIntsM)    nextState = WAKE;
        else if (toEn && cntMsb)  nextState = TIMEOUT;
      end
      WAKE: begin
        // Holding here while stalled keeps the still-asserted wfiM from re-entering DRAIN.
        WFIDoneM = ~StallM & ~FlushM;
        if      (FlushM) nextState = IDLE;
        else if (!StallM) nextState = IDLE;
      end
      TIMEOUT: begin
        WFITimeoutM = ~FlushM;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase

    if (reset) begin
      nextState   = IDLE;
      WFIStallM   = 1'b0;
      SleepM      = 1'b0;
      WFITimeoutM = 1'b0;
      WFIDoneM    = 1'b0;
    end
  end

endmodule

// File: tb/tb_wfi_ctrl.sv
// Randomized and scenario-driven bench for wfi_ctrl against a behavioural model
// that tracks "waiting / drained / waking / timing out" and elapsed wait cycles.
module tb_wfi_ctrl;

  localparam int TOB      = 4;
  localparam int TO_LIMIT = 1 << TOB;

  logic       clk = 1'b0;
  logic       reset;
  logic       wfiM, StallM, FlushM, PendingIntsM, LSUBusyM;
  logic [1:0] PrivilegeModeW;
  logic       STATUS_TW;
  logic       WFIStallM, SleepM, WFITimeoutM, WFIDoneM;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model
  bit mWaiting, mDrained, mWaking, mTimingOut;
  int mWaitCycles;
  bit eStall, eSleep, eTimeout, eDone;

  int doneSeen, timeoutSeen;

  wfi_ctrl #(.WFI_TIMEOUT_BIT(TOB), .U_SUPPORTED(1'b1), .S_SUPPORTED(1'b1)) dut (
    .clk(clk), .reset(reset), .wfiM(wfiM), .StallM(StallM), .FlushM(FlushM),
    .PendingIntsM(PendingIntsM), .LSUBusyM(LSUBusyM), .PrivilegeModeW(PrivilegeModeW),
    .STATUS_TW(STATUS_TW), .WFIStallM(WFIStallM), .SleepM(SleepM),
    .WFITimeoutM(WFITimeoutM), .WFIDoneM(WFIDoneM)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit modelToEn();
    // Timeout applies to U mode always, and to S mode when TW is set.
    if (PrivilegeModeW == 2'b00) return 1'b1;
    if (STATUS_TW && PrivilegeModeW != 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelOutputs();
    eStall = 0; eSleep = 0; eTimeout = 0; eDone = 0;
    if (reset) return;
    if (mWaiting) begin
      eStall = 1;
      eSleep = mDrained;
    end else if (mWaking) begin
      eDone = !StallM && !FlushM;
    end else if (mTimingOut) begin
      eTimeout = !FlushM;
    end else begin
      eStall = wfiM && !PendingIntsM && !FlushM;
      eDone  = wfiM && PendingIntsM && !FlushM && !StallM;
    end
  endfunction

  function automatic void modelAdvance();
    if (reset || FlushM) begin
      mWaiting = 0; mDrained = 0; mWaking = 0; mTimingOut = 0; mWaitCycles = 0;
    end else if (mWaiting) begin
      if (PendingIntsM) begin
        mWaiting = 0; mDrained = 0; mWaking = 1;
      end else if (modelToEn() && mWaitCycles >= TO_LIMIT) begin
        mWaiting = 0; mDrained = 0; mTimingOut = 1;
      end else begin
        if (!LSUBusyM) mDrained = 1;
        mWaitCycles++;
      end
    end else if (mWaking) begin
      mWaking = StallM;
    end else if (mTimingOut) begin
      mTimingOut = 0;
    end else if (wfiM && !PendingIntsM) begin
      mWaiting = 1; mDrained = 0; mWaitCycles = 0;
    end
  endfunction

  // Inputs are already driven; compare on the falling edge, then advance at the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
    modelOutputs();
    checkVal("WFIStallM",   int'(WFIStallM),   int'(eStall));
    checkVal("SleepM",      int'(SleepM),      int'(eSleep));
    checkVal("WFITimeoutM", int'(WFITimeoutM), int'(eTimeout));
    checkVal("WFIDoneM",    int'(WFIDoneM),    int'(eDone));
    if (WFIDoneM === 1'b1)    doneSeen++;
    if (WFITimeoutM === 1'b1) timeoutSeen++;
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic drive(input bit w, input bit st, input bit fl, input bit pi,
                       input bit busy, input bit [1:0] priv, input bit tw);
    wfiM = w; StallM = st; FlushM = fl; PendingIntsM = pi; LSUBusyM = busy;
    PrivilegeModeW = priv; STATUS_TW = tw;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Pending interrupt already present: immediate retire, no stall
    drive(1, 0, 0, 1, 0, 2'b11, 0);
    doneSeen = 0;
    step();
    checkVal("immediate_done_count", doneSeen, 1);
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step();

    // Drain with busy memory, sleep, then interrupt
    doneSeen = 0;
    drive(1, 0, 0, 0, 1, 2'b11, 0);
    for (int i = 0; i < 4; i++) step();
    LSUBusyM = 0;
    step(); step();
    PendingIntsM = 1;
    step();
    step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step(); step();
    checkVal("drain_wake_done_count", doneSeen, 1);

    // U-mode timeout, repeated twice to confirm the counter restarts from zero
    for (int rep = 0; rep < 2; rep++) begin
      timeoutSeen = 0;
      drive(1, 0, 0, 0, 0, 2'b00, 0);
      for (int i = 0; i < 40 && timeoutSeen == 0; i++) step();
      drive(0, 0, 1, 0, 0, 2'b00, 0);
      step();
      FlushM = 0;
      step(); step();
      checkVal("u_timeout_count", timeoutSeen, 1);
    end

    // M mode, TW=0: sleeps indefinitely, then wakes on interrupt
    timeoutSeen = 0;
    doneSeen = 0;
    drive(1, 0, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 100; i++) step();
    checkVal("m_sleep_still", int'(SleepM), 1);
    PendingIntsM = 1;
    step(); step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step();
    checkVal("m_no_timeout", timeoutSeen, 0);
    checkVal("m_wake_done", doneSeen, 1);

    // Interrupt arriving on the very cycle the timeout would fire
    timeoutSeen = 0;
    drive(1, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 40 && !(mWaiting && mWaitCycles >= TO_LIMIT); i++) step();
    checkVal("reached_timeout_edge", int'(mWaiting && mWaitCycles >= TO_LIMIT), 1);
    PendingIntsM = 1;
    step(); step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step(); step();
    checkVal("race_no_timeout", timeoutSeen, 0);

    // Flush while sleeping: back to idle, no pulses
    doneSeen = 0; timeoutSeen = 0;
    drive(1, 0, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 5; i++) step();
    FlushM = 1;
    step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step(); step();
    checkVal("flush_no_pulses", doneSeen + timeoutSeen, 0);

    // StallM holds the WAKE retire pulse
    doneSeen = 0;
    drive(1, 0, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 4; i++) step();
    PendingIntsM = 1;
    step();
    StallM = 1;
    step(); step();
    checkVal("stalled_wake_no_done", doneSeen, 0);
    StallM = 0;
    step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    step(); step();
    checkVal("released_wake_done", doneSeen, 1);

    // Reset mid-sleep
    drive(1, 0, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 2'b11, 0);
    reset = 1'b0;
    step();
    checkVal("post_reset_stall", int'(WFIStallM), 0);
    checkVal("post_reset_sleep", int'(SleepM), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wfiM         = ($urandom_range(0, 3) != 0);
      StallM       = ($urandom_range(0, 5) == 0);
      FlushM       = ($urandom_range(0, 40) == 0);
      PendingIntsM = ($urandom_range(0, 30) == 0);
      LSUBusyM     = ($urandom_range(0, 2) == 0);
      reset        = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 50) == 0) PrivilegeModeW = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 50) == 0) STATUS_TW = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
